periph_bus_arbiter: RTL and testbench
=====================================

// Module: periph_bus_arbiter
// PURPOSE
//  Shares the single peripheral data bus (addr/wdata/rdata/store_type, valid/ready) among
//  N_REQ requesters: port 0 is the core data port, further ports serve DMA/debug masters.
//  Round-robin grant per transaction. Each accepted request is registered and driven onto
//  the bus until completion, then the response is routed back to the granted requester.
//  Sits between core and the peripheral interconnect.
// PARAMETERS
//  N_REQ           2     number of requesters (>=2); index 0 = core
//  TIMEOUT_CYCLES  255   BUSY cycles without bus_ready before forced abort (ARB_TIMEOUT_EN only)
// PORTS
//  clock           in   1               single clock, rising edge
//  reset           in   1               synchronous, active-high
//  req_valid       in   [N_REQ]         requester i asks for a transfer
//  req_addr        in   [N_REQ][63:0]   transfer address
//  req_wdata       in   [N_REQ][63:0]   store data
//  req_store_type  in   [N_REQ] mem_store_type_t  zero = load; nonzero = store width
//  req_ready       out  [N_REQ]         one-hot, 1-cycle pulse: transfer i complete
//  req_rdata       out  64              load data, valid with req_ready (shared by all ports)
//  bus_addr        out  64              registered address to peripherals
//  bus_wdata       out  64              registered store data
//  bus_store_type  out  mem_store_type_t  registered store type
//  bus_valid       out  1               transfer outstanding on bus
//  bus_ready       in   1               peripheral completes transfer this cycle
//  bus_rdata       in   64              peripheral load data, valid with bus_ready
//  grant_id        out  $clog2(N_REQ)   index of current/last granted requester
//  bus_error       out  1               1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: state IDLE; last_grant = N_REQ-1 (port 0 wins first); all outputs 0.
//  FSM IDLE->BUSY: any req_valid; winner = first asserted index scanning last_grant+1,
//   +2,... modulo N_REQ. Latch winner's addr/wdata/store_type into bus_* regs;
//   grant_id/last_grant <= winner.
//  BUSY: bus_valid=1; bus_* stable. On bus_ready: req_ready[grant_id]=1 and
//   req_rdata=bus_rdata combinationally in that cycle; next state IDLE; bus_valid drops.
//  Latency: req_valid at cycle t -> bus_valid at t+1 -> req_ready earliest t+1 (ready same
//   cycle). At most one transfer per 2 cycles; IDLE always lasts >=1 cycle between grants.
//  Requester rule: hold req_valid and fields stable until its req_ready pulse. Deassert or
//   present a new request in the following cycle. Withdrawal before ready is ignored; the
//   latched transfer completes and req_ready still pulses.
//  req_rdata is 0 whenever no req_ready is asserted. Ungranted ports never see req_ready.
//  Simultaneous requests: round-robin only; no port starves. With all N_REQ requesting
//   continuously, each is granted once per N_REQ transfers.
//  bus_ready while IDLE: ignored.
//  reset mid-BUSY: transfer abandoned, no req_ready pulse, state IDLE next cycle.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: 16-bit counter cleared on IDLE->BUSY and incremented each BUSY
//   cycle without bus_ready. When it equals TIMEOUT_CYCLES:
//   - req_ready[grant_id]=1, req_rdata=ARB_ERR_RDATA, bus_error=1, all for 1 cycle;
//   - next state IDLE.
//   bus_ready in the same cycle wins (normal completion, no error).
//  ARB_TIMEOUT_EN undefined: BUSY waits indefinitely; bus_error tied 0; no counter.
// STRUCTURE
//  structures package: typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
//   localparam logic [63:0] ARB_ERR_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;
//   mem_store_type_t reused unchanged.
//  Sub-module rr_priority_picker #(N): inputs req[N] and last[$clog2(N)]; outputs any,
//   idx. Purely combinational rotate / find-first / unrotate.
// TESTING
//  1 Single core load: req_valid[0], addr 0x2000_0010; bus_ready 3 cycles after
//    bus_valid with rdata 0x1234 -> req_ready[0] pulses once, req_rdata=0x1234, grant_id=0.
//  2 Both ports request continuously from reset with 0-wait bus -> grants 0,1,0,1; one
//    req_ready every 2 cycles; bus_addr matches each grantee's addr.
//  3 Port 1 store (type nonzero, wdata 0xCAFE) while port 0 idle -> bus_store_type and
//    bus_wdata=0xCAFE stable for the whole BUSY; port 0 req_ready stays 0.
//  4 Reset asserted during BUSY -> next cycle bus_valid=0, all outputs 0, no req_ready;
//    first post-reset grant goes to port 0.
//  5 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_ready never asserted -> at BUSY cycle 8:
//    req_ready pulse, req_rdata=0xDEADBEEFDEADBEEF, bus_error=1; then IDLE.
//  6 Without ARB_TIMEOUT_EN, same stimulus for 1000 cycles -> bus_valid held high,
//    bus_error=0, no req_ready.

Source files
------------

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
package periph_bus_arbiter_pkg;

  // Zero means load; any nonzero value is the store width.
  typedef enum logic [2:0] {
    MEM_LOAD    = 3'd0,
    MEM_STORE_B = 3'd1,
    MEM_STORE_H = 3'd2,
    MEM_STORE_W = 3'd3,
    MEM_STORE_D = 3'd4
  } mem_store_type_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // Load data returned to the requester when a transfer is aborted on timeout.
  localparam logic [63:0] ARB_ERR_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;

  // Width of the BUSY stall counter used by the optional timeout.
  localparam int unsigned ARB_TMO_CNT_W = 16;

endpackage

// File: rtl/periph_bus_arbiter_rr_priority_picker.sv
// Round-robin priority picker: the first requester after the last grant wins,
// scanning upward with wrap-around. Purely combinational.
module rr_priority_picker #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  logic [N-1:0] w_rot;

  // Rotate the request vector so bit 0 is the port right after the last grant.
  always_comb begin
    int            src;
    logic [IW-1:0] src_idx;
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave it holding its old value (no latch).
    w_rot   = '0;
    src     = 0;
    src_idx = '0;
    for (int k = 0; k < N; k++) begin
      src = int'(i_last) + 1 + k;
      if (src >= N) src = src - N;
      if (src >= N) src = src - N;
      src_idx  = IW'(src);
      w_rot[k] = i_req[src_idx];
    end
  end

  // Find the first set bit of the rotated vector and map it back to a port index.
  always_comb begin
    logic found;
    int   off;
    int   sum;
    o_any = |w_rot;
    found = 1'b0;
    off   = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && w_rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = int'(i_last) + 1 + off;
    if (sum >= N) sum = sum - N;
    if (sum >= N) sum = sum - N;
    o_idx = IW'(sum);
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Peripheral bus arbiter: shares one registered peripheral bus among N_REQ
// requesters (port 0 = core) with round-robin grant per transaction. The
// winner's request is latched onto the bus until the peripheral completes,
// then the response is routed back to that requester as a 1-cycle pulse.
// Optional feature: define ARB_TIMEOUT_EN to abort a transfer that sees no
// bus_ready for TIMEOUT_CYCLES BUSY cycles (error data + bus_error pulse).
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter  int N_REQ          = 2,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int IW             = $clog2(N_REQ)
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0][63:0]      i_req_addr,
  input  logic [N_REQ-1:0][63:0]      i_req_wdata,
  input  mem_store_type_t [N_REQ-1:0] i_req_store_type,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [63:0]                 o_req_rdata,
  output logic [63:0]                 o_bus_addr,
  output logic [63:0]                 o_bus_wdata,
  output mem_store_type_t             o_bus_store_type,
  output logic                        o_bus_valid,
  input  logic                        i_bus_ready,
  input  logic [63:0]                 i_bus_rdata,
  output logic [IW-1:0]               o_grant_id,
  output logic                        o_bus_error
);

  arb_state_t      r_state;
  logic [IW-1:0]   r_last_grant;
  logic [IW-1:0]   r_grant_id;
  logic [63:0]     r_bus_addr;
  logic [63:0]     r_bus_wdata;
  mem_store_type_t r_bus_store_type;
  logic            r_bus_valid;

  logic            w_pick_any;
  logic [IW-1:0]   w_pick_idx;
  logic            w_done;
  logic            w_timeout;
  logic            w_finish;

  rr_priority_picker #(
    .N (N_REQ)
  ) u_picker (
    .i_req  (i_req_valid),
    .i_last (r_last_grant),
    .o_any  (w_pick_any),
    .o_idx  (w_pick_idx)
  );

  // A transfer held in reset is abandoned, so it must never report completion.
  assign w_done   = (r_state == ARB_BUSY) && i_bus_ready && !i_reset;
  assign w_finish = w_done || w_timeout;

`ifdef ARB_TIMEOUT_EN
  logic [ARB_TMO_CNT_W-1:0] r_tmo_cnt;
  logic [ARB_TMO_CNT_W-1:0] w_tmo_cnt_inc;

  // The counter holds the stalled cycles already seen; the abort fires in the
  // BUSY cycle that would bring it to TIMEOUT_CYCLES. bus_ready that cycle wins.
  assign w_tmo_cnt_inc = r_tmo_cnt + 1'b1;
  assign w_timeout     = (r_state == ARB_BUSY) && !i_bus_ready && !i_reset &&
                         (w_tmo_cnt_inc == ARB_TMO_CNT_W'(TIMEOUT_CYCLES));

  // Stall counter: cleared on each new grant, counts BUSY cycles without bus_ready.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ARB_IDLE) begin
      r_tmo_cnt <= '0;
    end else if (!i_bus_ready) begin
      r_tmo_cnt <= w_tmo_cnt_inc;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Arbiter FSM: grant in IDLE, hold the latched transfer in BUSY until it ends.
  always_ff @(posedge i_clock) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (i_reset) begin
      r_state          <= ARB_IDLE;
      r_last_grant     <= IW'(N_REQ - 1);
      r_grant_id       <= '0;
      r_bus_addr       <= '0;
      r_bus_wdata      <= '0;
      r_bus_store_type <= MEM_LOAD;
      r_bus_valid      <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_any) begin
            r_state          <= ARB_BUSY;
            r_bus_valid      <= 1'b1;
            r_bus_addr       <= i_req_addr[w_pick_idx];
            r_bus_wdata      <= i_req_wdata[w_pick_idx];
            r_bus_store_type <= i_req_store_type[w_pick_idx];
            r_grant_id       <= w_pick_idx;
            r_last_grant     <= w_pick_idx;
          end
        end
        ARB_BUSY: begin
          if (w_finish) begin
            r_state     <= ARB_IDLE;
            r_bus_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Response routing: completion pulse and data go only to the granted port.
  always_comb begin
    o_req_ready = '0;
    o_req_rdata = '0;
    if (w_done) begin
      o_req_ready[r_grant_id] = 1'b1;
      o_req_rdata             = i_bus_rdata;
    end else if (w_timeout) begin
      o_req_ready[r_grant_id] = 1'b1;
      o_req_rdata             = ARB_ERR_RDATA;
    end
  end

  assign o_bus_addr       = r_bus_addr;
  assign o_bus_wdata      = r_bus_wdata;
  assign o_bus_store_type = r_bus_store_type;
  assign o_bus_valid      = r_bus_valid;
  assign o_grant_id       = r_grant_id;
  assign o_bus_error      = w_timeout;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level round-robin model.
// Build with or without ARB_TIMEOUT_EN; the timeout scenario follows the macro.
module tb_periph_bus_arbiter;
  import periph_bus_arbiter_pkg::*;

  localparam int N   = 3;
  localparam int IW  = $clog2(N);
  localparam int TMO = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            req_valid;
  logic [N-1:0][63:0]      req_addr;
  logic [N-1:0][63:0]      req_wdata;
  mem_store_type_t [N-1:0] req_st;
  logic [N-1:0]            req_ready;
  logic [63:0]             req_rdata;
  logic [63:0]             bus_addr;
  logic [63:0]             bus_wdata;
  mem_store_type_t         bus_st;
  logic                    bus_valid;
  logic                    bus_ready;
  logic [63:0]             bus_rdata;
  logic [IW-1:0]           grant_id;
  logic                    bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level requester model for the random phase.
  bit              pend   [N];
  logic [63:0]     p_addr [N];
  logic [63:0]     p_wdata[N];
  mem_store_type_t p_st   [N];
  int              model_last;

  always #5 clk = ~clk;

  periph_bus_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_req_valid      (req_valid),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .i_req_store_type (req_st),
    .o_req_ready      (req_ready),
    .o_req_rdata      (req_rdata),
    .o_bus_addr       (bus_addr),
    .o_bus_wdata      (bus_wdata),
    .o_bus_store_type (bus_st),
    .o_bus_valid      (bus_valid),
    .i_bus_ready      (bus_ready),
    .i_bus_rdata      (bus_rdata),
    .o_grant_id       (grant_id),
    .o_bus_error      (bus_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    bus_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] onehot(input int i);
    logic [63:0] v;
    v = 64'd1 << i;
    return v;
  endfunction

  // Round-robin rule: first pending port scanning last+1, last+2, ... mod N.
  function automatic int rr_winner(input int last);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic new_req(input int i);
    p_addr[i]    = {$urandom, $urandom};
    p_wdata[i]   = {$urandom, $urandom};
    p_st[i]      = mem_store_type_t'($urandom_range(4, 0));
    pend[i]      = 1'b1;
    req_valid[i] = 1'b1;
    req_addr[i]  = p_addr[i];
    req_wdata[i] = p_wdata[i];
    req_st[i]    = p_st[i];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          bad;
    int          exp_g2[10];
    logic [63:0] a_exp;
    int          win;
    int          wait_n;
    bit          withdraw;
    bit          any;
    logic [63:0] rd;

    exp_g2 = '{0, 1, 0, 1, 2, 0, 1, 2, 0, 1};
    rst       = 1'b1;
    req_valid = '0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_st[i]    = MEM_LOAD;
    end
    tick();
    tick();

    // Reset state: every output low.
    check("rst_bus_valid", bus_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_req_rdata", req_rdata, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_error", bus_error, 0);

    // Single core load with bus_ready 3 cycles after bus_valid.
    do_reset();
    req_addr[0]  = 64'h2000_0010;
    req_st[0]    = MEM_LOAD;
    req_valid[0] = 1'b1;
    #1;
    check("t1_idle_bus_valid", bus_valid, 0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      check("t1_wait_req_ready", req_ready, 0);
      check("t1_bus_valid", bus_valid, 1);
      check("t1_bus_addr", bus_addr, 64'h2000_0010);
      tick();
    end
    bus_ready = 1'b1;
    bus_rdata = 64'h1234;
    #1;
    check("t1_req_ready", req_ready, 64'b001);
    check("t1_req_rdata", req_rdata, 64'h1234);
    check("t1_grant_id", grant_id, 0);
    tick();
    req_valid[0] = 1'b0;
    bus_ready    = 1'b0;
    #1;
    check("t1_after_req_ready", req_ready, 0);
    check("t1_after_req_rdata", req_rdata, 0);
    check("t1_after_bus_valid", bus_valid, 0);

    // Continuous requests with a zero-wait bus; port 2 joins after 4 transfers.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = 64'h1000 * (i + 1);
      req_valid[i] = 1'b1;
    end
    req_addr[2] = 64'h3000;
    bus_ready   = 1'b1;
    bus_rdata   = 64'h77;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) req_valid[2] = 1'b1;
      #1;
      check("t2_idle_req_ready", req_ready, 0);
      check("t2_idle_bus_valid", bus_valid, 0);
      a_exp = req_addr[exp_g2[k]];
      tick();
      check("t2_grant_id", grant_id, exp_g2[k]);
      check("t2_bus_addr", bus_addr, a_exp);
      check("t2_req_ready", req_ready, onehot(exp_g2[k]));
      check("t2_req_rdata", req_rdata, 64'h77);
      req_addr[exp_g2[k]] = req_addr[exp_g2[k]] + 64'd1;
      tick();
    end
    req_valid = '0;
    bus_ready = 1'b0;
    tick();

    // Port 1 store while port 0 is idle; bus fields stable across BUSY.
    req_addr[1]  = 64'h3000_0008;
    req_wdata[1] = 64'hCAFE;
    req_st[1]    = MEM_STORE_W;
    req_valid[1] = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        bus_ready = 1'b1;
        bus_rdata = 64'hABCD;
      end
      #1;
      check("t3_bus_store_type", bus_st, MEM_STORE_W);
      check("t3_bus_wdata", bus_wdata, 64'hCAFE);
      check("t3_grant_id", grant_id, 1);
      check("t3_req_ready", req_ready, (c == 4) ? 64'b010 : 64'b000);
      tick();
    end
    req_valid[1] = 1'b0;
    bus_ready    = 1'b0;
    #1;
    check("t3_after_req_ready", req_ready, 0);

    // Reset in the middle of a port-0 transfer.
    tick();
    req_addr[0]  = 64'h4000;
    req_wdata[0] = 64'h55;
    req_st[0]    = MEM_STORE_D;
    req_valid[0] = 1'b1;
    tick();
    check("t4_busy_bus_valid", bus_valid, 1);
    check("t4_busy_grant_id", grant_id, 0);
    rst = 1'b1;
    #1;
    check("t4_rst_req_ready", req_ready, 0);
    tick();
    check("t4_post_bus_valid", bus_valid, 0);
    check("t4_post_req_ready", req_ready, 0);
    check("t4_post_bus_addr", bus_addr, 0);
    check("t4_post_bus_wdata", bus_wdata, 0);
    check("t4_post_bus_store_type", bus_st, 0);
    check("t4_post_grant_id", grant_id, 0);
    check("t4_post_bus_error", bus_error, 0);
    rst          = 1'b0;
    req_addr[1]  = 64'h5000;
    req_valid    = 3'b011;
    tick();
    check("t4_first_grant", grant_id, 0);
    check("t4_first_bus_addr", bus_addr, 64'h4000);
    bus_ready = 1'b1;
    bus_rdata = 64'h9;
    #1;
    check("t4_first_req_ready", req_ready, 64'b001);
    tick();
    req_valid = '0;
    bus_ready = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Timeout abort on the TMO-th stalled BUSY cycle.
    req_addr[0]  = 64'h6000;
    req_st[0]    = MEM_LOAD;
    req_valid[0] = 1'b1;
    tick();
    for (int c = 1; c <= TMO; c++) begin
      if (c < TMO) begin
        check("t5_wait_req_ready", req_ready, 0);
        check("t5_wait_bus_error", bus_error, 0);
      end else begin
        check("t5_tmo_req_ready", req_ready, 64'b001);
        check("t5_tmo_req_rdata", req_rdata, 64'hDEAD_BEEF_DEAD_BEEF);
        check("t5_tmo_bus_error", bus_error, 1);
      end
      tick();
    end
    check("t5_after_bus_valid", bus_valid, 0);
    check("t5_after_bus_error", bus_error, 0);
    // bus_ready in the timeout cycle completes normally.
    req_addr[0] = 64'h6008;
    tick();
    for (int c = 1; c <= TMO; c++) begin
      if (c == TMO) begin
        bus_ready = 1'b1;
        bus_rdata = 64'h55;
      end
      #1;
      if (c == TMO) begin
        check("t5_race_req_ready", req_ready, 64'b001);
        check("t5_race_req_rdata", req_rdata, 64'h55);
        check("t5_race_bus_error", bus_error, 0);
      end
      tick();
    end
    req_valid = '0;
    bus_ready = 1'b0;
    tick();
`else
    // No timeout: a stalled transfer stays on the bus indefinitely.
    req_addr[0]  = 64'h6000;
    req_valid[0] = 1'b1;
    tick();
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (bus_valid !== 1'b1 || req_ready !== '0 || bus_error !== 1'b0) bad++;
      tick();
    end
    check("t6_stall_bad_cycles", bad, 0);
    check("t6_still_bus_valid", bus_valid, 1);
`endif

    // Randomized traffic against the round-robin model.
    do_reset();
    model_last = N - 1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int t = 0; t < 60; t++) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) new_req(i);
        if (pend[i]) any = 1'b1;
      end
      if (!any) new_req($urandom_range(N - 1, 0));
      bus_ready = 1'($urandom_range(1, 0));
      bus_rdata = {$urandom, $urandom};
      #1;
      check("rnd_idle_req_ready", req_ready, 0);
      check("rnd_idle_req_rdata", req_rdata, 0);
      check("rnd_idle_bus_valid", bus_valid, 0);
      win        = rr_winner(model_last);
      model_last = win;
      tick();
      bus_ready = 1'b0;
      wait_n    = $urandom_range(3, 0);
      withdraw  = ($urandom_range(3, 0) == 0);
      for (int c = 0; c <= wait_n; c++) begin
        rd = {$urandom, $urandom};
        if (c == wait_n) begin
          bus_ready = 1'b1;
          bus_rdata = rd;
        end
        #1;
        check("rnd_bus_valid", bus_valid, 1);
        check("rnd_grant_id", grant_id, win);
        check("rnd_bus_addr", bus_addr, p_addr[win]);
        check("rnd_bus_wdata", bus_wdata, p_wdata[win]);
        check("rnd_bus_store_type", bus_st, p_st[win]);
        check("rnd_bus_error", bus_error, 0);
        check("rnd_req_ready", req_ready, (c == wait_n) ? onehot(win) : 64'd0);
        check("rnd_req_rdata", req_rdata, (c == wait_n) ? rd : 64'd0);
        if (c == 0 && withdraw) begin
          req_valid[win] = 1'b0;
          req_addr[win]  = ~p_addr[win];
          req_wdata[win] = ~p_wdata[win];
        end
        tick();
      end
      bus_ready      = 1'b0;
      pend[win]      = 1'b0;
      req_valid[win] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
